// File: rtl/prng_nlfsr_gen.sv
// Parametrised nonlinear-feedback shift-register PRNG with warm-up, runtime reseed,
// valid/ready output, all-zero lockup recovery and a handshake counter.
//
// state  | meaning
// -------+--------------------------------------------------------------
// WARMUP | free-running steps after reset or reseed, no output offered
// RUN    | one folded word offered per cycle, stepping only on reload
module prng_nlfsr_gen #(
  parameter int unsigned      WIDTH  = 256,
  parameter int unsigned      OUT_W  = 64,
  parameter logic [WIDTH-1:0] SEED   = {WIDTH/32{32'hA5A5_5A5B}},
  parameter int unsigned      WARMUP = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             lockup,
  output logic [31:0]      word_count
);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fsm_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

  fsm_t             fsm_q, fsm_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [31:0]      wc_q, wc_d;
  logic             lock_q;

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wr_val;
  logic             wr_en;
  logic             zero_hit;

  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] s);
    logic fb;
    fb = s[WIDTH-1] ^ s[WIDTH/2] ^ s[WIDTH/4] ^ s[0] ^ (s[WIDTH/3] & s[WIDTH/5]);
    return {s[WIDTH-2:0], fb};
  endfunction

  function automatic logic [OUT_W-1:0] fold_fn(input logic [WIDTH-1:0] s);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(WIDTH / OUT_W); i++) begin
      acc = acc ^ s[i*OUT_W +: OUT_W];
    end
    return acc;
  endfunction

  assign step_val = step_fn(state_q);

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    wc_d    = wc_q;
    wr_en   = 1'b0;
    wr_val  = step_val;

    // A handshake always counts, even when a reseed discards the reload.
    if (valid_q && out_ready) begin
      wc_d = wc_q + 32'd1;
    end

    if (seed_load) begin
      wr_en   = 1'b1;
      wr_val  = seed;
      cnt_d   = '0;
      valid_d = 1'b0;
      fsm_d   = ST_WARMUP;
    end else begin
      case (fsm_q)
        ST_WARMUP: begin
          wr_en = 1'b1;
          if (cnt_q == WARM_LAST) begin
            fsm_d = ST_RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (!valid_q || out_ready) begin
            wr_en   = 1'b1;
            data_d  = fold_fn(state_q);
            valid_d = 1'b1;
          end
        end
        default: begin
          fsm_d = ST_WARMUP;
        end
      endcase
    end
  end

  // Any all-zero value headed for the state register is replaced by SEED.
  assign zero_hit = wr_en && (wr_val == '0);

  always_comb begin
    state_d = state_q;
    if (wr_en) begin
      state_d = zero_hit ? SEED : wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= ST_WARMUP;
      cnt_q   <= '0;
      state_q <= SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
      wc_q    <= '0;
      lock_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
      lock_q  <= lock_q | zero_hit;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign busy       = (fsm_q == ST_WARMUP);
  assign lockup     = lock_q;
  assign word_count = wc_q;

endmodule
